// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl.
// The master side issues operands and a start strobe; the slave side (the
// adder controller) returns status and the registered result.
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/subtract controller.
// A single 4-bit adder is reused once per nibble, least significant first.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry chain is
// seeded with 1. Results appear on S/Cout/V only on the edge entering DONE.

module Adder4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic [4:0] total_s;

  assign total_s = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
  assign s_o     = total_s[3:0];
  assign cout_o  = total_s[4];
endmodule

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(32'd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [3:0]       nib_sum_s;
  logic             nib_cout_s;
  logic [W-1:0]     acc_upd_s;

  // Pick the operand nibbles addressed by idx (one-hot OR mux, no priority).
  always_comb begin
    nib_a_s = 4'h0;
    nib_b_s = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      nib_a_s = nib_a_s | (opa_q[i*4 +: 4] & {4{idx_q == IDX_W'(i)}});
      nib_b_s = nib_b_s | (opb_q[i*4 +: 4] & {4{idx_q == IDX_W'(i)}});
    end
  end

  Adder4bit u_adder (
    .a_i    (nib_a_s),
    .b_i    (nib_b_s),
    .cin_i  (carry_q),
    .s_o    (nib_sum_s),
    .cout_o (nib_cout_s)
  );

  // Accumulator image with this cycle's sum merged into nibble idx.
  always_comb begin
    acc_upd_s = acc_q;
    for (int i = 0; i < NIBBLES; i++) begin
      acc_upd_s[i*4 +: 4] = (idx_q == IDX_W'(i)) ? nib_sum_s : acc_q[i*4 +: 4];
    end
  end

  // Next-state, datapath capture and status decode.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub;
          idx_d   = IDX_ZERO;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        acc_d   = acc_upd_s;
        carry_d = nib_cout_s;
        if (idx_q == IDX_LAST) begin
          // Final nibble: publish the whole result in one step.
          idx_d   = IDX_ZERO;
          s_d     = acc_upd_s;
          cout_d  = nib_cout_s;
          v_d     = (opa_q[W-1] == opb_q[W-1]) && (acc_upd_s[W-1] != opa_q[W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= {W{1'b0}};
      opb_q   <= {W{1'b0}};
      acc_q   <= {W{1'b0}};
      s_q     <= {W{1'b0}};
      idx_q   <= IDX_ZERO;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl.
// Expected results are queued when an operation is launched and popped when
// the design raises done; between pulses S/Cout/V must hold the last result.
module tb_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [W-1:0] last_s;
  logic         last_c;
  logic         last_v;

  serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic written as plain add / subtract with a borrow.
  function automatic exp_t model_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t       e;
    logic [W:0] full;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      e.c  = ~full[W];
      e.s  = full[W-1:0];
      e.v  = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      e.c  = full[W];
      e.s  = full[W-1:0];
      e.v  = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    end
    return e;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = {W{1'b0}};
    bus.B     = {W{1'b0}};
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.S !== {W{1'b0}}) begin errors++; $display("FAIL reset_S: got %h expected 0", bus.S); end
    checks++; if (bus.Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout: got %b expected 0", bus.Cout); end
    checks++; if (bus.V !== 1'b0) begin errors++; $display("FAIL reset_V: got %b expected 0", bus.V); end
    bus.start = 1'b0;
    last_s = {W{1'b0}};
    last_c = 1'b0;
    last_v = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb_ [6];
    logic         tsub [6];
    logic [W-1:0] ts [6];
    logic         tc [6];
    logic         tv [6];
    string        tn [6];
    ta   = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h0000};
    tb_  = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0000};
    tsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ts   = '{16'h2233, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0000};
    tc   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tn   = '{"add", "carry_wrap", "ovf_add", "ovf_sub", "borrow", "sub_zero"};
    for (int t = 0; t < 6; t++) begin
      exp_t e;
      int   lat;
      bus.A     = ta[t];
      bus.B     = tb_[t];
      bus.sub   = tsub[t];
      bus.start = 1'b1;
      e.s = ts[t]; e.c = tc[t]; e.v = tv[t];
      sb.push_back(e);
      lat = -1;
      for (int c = 0; c <= NIBBLES + 1; c++) begin
        @(negedge clk);
        if (c == 0) begin
          // Operands change right after acceptance and must not matter.
          bus.start = 1'b0;
          bus.A     = ~ta[t];
          bus.B     = W'($urandom);
          bus.sub   = ~tsub[t];
        end
        checks++; if (bus.busy !== (c < NIBBLES)) begin errors++; $display("FAIL %s_busy c=%0d: got %b expected %b", tn[t], c, bus.busy, (c < NIBBLES)); end
        checks++; if (bus.done !== (c == NIBBLES)) begin errors++; $display("FAIL %s_done c=%0d: got %b expected %b", tn[t], c, bus.done, (c == NIBBLES)); end
        if (bus.done === 1'b1 && sb.size() > 0) begin
          lat = c;
          e = sb.pop_front();
          checks++;
          if ({bus.S, bus.Cout, bus.V} !== {e.s, e.c, e.v}) begin
            errors++;
            $display("FAIL %s_result: got S=%h Cout=%b V=%b expected S=%h Cout=%b V=%b", tn[t], bus.S, bus.Cout, bus.V, e.s, e.c, e.v);
          end
          last_s = e.s; last_c = e.c; last_v = e.v;
        end else begin
          checks++;
          if ({bus.S, bus.Cout, bus.V} !== {last_s, last_c, last_v}) begin
            errors++;
            $display("FAIL %s_hold c=%0d: got S=%h Cout=%b V=%b expected S=%h Cout=%b V=%b", tn[t], c, bus.S, bus.Cout, bus.V, last_s, last_c, last_v);
          end
        end
      end
      checks++; if (lat != NIBBLES) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", tn[t], lat, NIBBLES); end
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    int nxt;
    int dones;
    int prev_c;
    exp_t e;
    cnt    = 0;
    dones  = 0;
    prev_c = -1;
    for (int c = 0; c < 32; c++) begin
      bus.start = (c < 20);
      if (c < 20) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
      end
      // cnt tracks state after an edge: 0 idle, NIBBLES+1..2 run, 1 done.
      if (cnt == 0 && bus.start) begin
        sb.push_back(model_op(bus.A, bus.B, bus.sub));
        nxt = NIBBLES + 1;
      end else begin
        nxt = (cnt > 0) ? cnt - 1 : 0;
      end
      @(negedge clk);
      cnt = nxt;
      checks++; if (bus.busy !== (cnt >= 2)) begin errors++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, bus.busy, (cnt >= 2)); end
      checks++; if (bus.done !== (cnt == 1)) begin errors++; $display("FAIL b2b_done c=%0d: got %b expected %b", c, bus.done, (cnt == 1)); end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.S, bus.Cout, bus.V} !== {e.s, e.c, e.v}) begin
          errors++;
          $display("FAIL b2b_result c=%0d: got S=%h Cout=%b V=%b expected S=%h Cout=%b V=%b", c, bus.S, bus.Cout, bus.V, e.s, e.c, e.v);
        end
        last_s = e.s; last_c = e.c; last_v = e.v;
        if (c < 20) begin
          dones++;
          if (prev_c >= 0) begin
            checks++; if (c - prev_c != NIBBLES + 2) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", c - prev_c, NIBBLES + 2); end
          end
          prev_c = c;
        end
      end else begin
        checks++;
        if ({bus.S, bus.Cout, bus.V} !== {last_s, last_c, last_v}) begin
          errors++;
          $display("FAIL b2b_hold c=%0d: got S=%h expected S=%h", c, bus.S, last_s);
        end
      end
    end
    checks++; if (dones != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", dones); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d expected 0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus.A     = 16'h1234;
    bus.B     = 16'h0FFF;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    // Second RUN cycle: pulse reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_run_done: got %b expected 0", bus.done); end
    checks++; if (bus.S !== {W{1'b0}}) begin errors++; $display("FAIL rst_run_S: got %h expected 0", bus.S); end
    checks++; if (bus.Cout !== 1'b0) begin errors++; $display("FAIL rst_run_Cout: got %b expected 0", bus.Cout); end
    checks++; if (bus.V !== 1'b0) begin errors++; $display("FAIL rst_run_V: got %b expected 0", bus.V); end
    sb.delete();
    last_s = {W{1'b0}}; last_c = 1'b0; last_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.S} !== {1'b0, 1'b0, {W{1'b0}}}) begin
        errors++;
        $display("FAIL rst_run_quiet c=%0d: got busy=%b done=%b S=%h expected 0 0 0", c, bus.busy, bus.done, bus.S);
      end
    end
    bus.A     = 16'h0001;
    bus.B     = 16'h0001;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    lat = -1;
    for (int c = 0; c <= NIBBLES + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1 && lat < 0) begin
        lat = c;
        checks++;
        if ({bus.S, bus.Cout, bus.V} !== {16'h0002, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rst_then_add: got S=%h Cout=%b V=%b expected S=0002 Cout=0 V=0", bus.S, bus.Cout, bus.V);
        end
      end
    end
    checks++; if (lat != NIBBLES) begin errors++; $display("FAIL rst_then_add_latency: got %0d expected %0d", lat, NIBBLES); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    @(negedge clk);
    test_arith();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: request an operation; sampled only in IDLE.
REQ-005 SHALL have port sub, input, 1: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port A, input, W: first operand; sampled with start.
REQ-007 SHALL have port B, input, W: second operand; sampled with start.
REQ-008 SHALL have port busy, output, 1: high while in RUN.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, high while in DONE.
REQ-010 SHALL have port S, output, W: result, two's-complement wrap.
REQ-011 SHALL have port Cout, output, 1: carry out of bit W-1. For sub, 1 means no borrow.
REQ-012 SHALL have port V, output, 1: signed overflow of the last operation.

Function
REQ-013 SHALL perform all arithmetic through exactly one instance of Adder4bit, reused once per nibble, least significant nibble first.
REQ-014 SHALL implement the states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at edge k, the block SHALL capture:
- opA = A;
- opB = sub ? ~B : B;
- carry register = sub;
- nibble index = 0;
- state <= RUN.
REQ-016 At each edge in RUN, the block SHALL:
- drive the adder with opA[idx], opB[idx] and the carry register;
- store the 4-bit sum into internal accumulator nibble idx;
- load the carry register with the adder's Cout;
- increment idx.
REQ-017 When idx = NIBBLES-1 in RUN, that edge SHALL also move the state to DONE; the final RUN edge is edge k+NIBBLES.
REQ-018 In DONE the block SHALL assert done for exactly one cycle, then return to IDLE on the next edge.
- Latency: done is high from edge k+NIBBLES to edge k+NIBBLES+1.
REQ-019 S, Cout and V SHALL update only on the edge that enters DONE, and SHALL hold that value until the next entry into DONE.
- Intermediate nibbles are never visible on S.
REQ-020 V SHALL equal (opA[W-1] == opB[W-1]) AND (S[W-1] != opA[W-1]), where opB is the operand after inversion.
REQ-021 start SHALL be ignored in RUN and DONE, with no queuing.
- If start is held high, operations run back-to-back, one accepted every NIBBLES+2 cycles.
REQ-022 Changes on A, B or sub after acceptance SHALL NOT affect the operation in progress.
REQ-023 busy and done SHALL never be high in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force:
- state = IDLE;
- busy = 0, done = 0;
- S = 0, Cout = 0, V = 0;
- idx = 0, carry register = 0, opA = 0, opB = 0, accumulator = 0.
REQ-025 Reset asserted during RUN or DONE SHALL abandon the operation without producing a done pulse.
- After release, the first accepted start SHALL produce a correct result.

Verification
REQ-026 The bench SHALL check add: A=0x1234, B=0x0FFF, sub=0 -> S=0x2233, Cout=0, V=0, with done exactly 4 cycles after the start edge.
REQ-027 The bench SHALL check carry wrap: A=0xFFFF, B=0x0001, sub=0 -> S=0x0000, Cout=1, V=0.
REQ-028 The bench SHALL check signed overflow:
- A=0x7FFF, B=0x0001, sub=0 -> S=0x8000, Cout=0, V=1;
- A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, Cout=1, V=1.
REQ-029 The bench SHALL check borrow: A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, Cout=0, V=0.
REQ-030 The bench SHALL check start held high for 20 cycles with A/B changing every cycle:
- exactly 3 done pulses spaced 6 cycles apart;
- each result matches the operands present on its accepting edge.
REQ-031 The bench SHALL check rst_n pulsed low at the 2nd RUN cycle:
- outputs go to 0 asynchronously and no done pulse follows;
- a subsequent 0x0001+0x0001 gives S=0x0002.
